// File: rtl/multi_channel_pwm_clock_pkg.sv
// Shared constants for the multi-channel PWM tick generator.
// Holds the default period/width/channel count, the reset duty, and a
// helper that sizes the channel-select bus from the channel count.
package multi_channel_pwm_clock_pkg;

    localparam int unsigned DEF_PERIOD = 250000;
    localparam int unsigned DEF_CNT_W  = 18;
    localparam int unsigned DEF_NUM_CH = 2;
    localparam int unsigned DEF_DUTY   = 0;

    // Bits needed to index n channels; never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((w < 31) && ((32'd1 << w) < n)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/multi_channel_pwm_clock_pwm_channel.sv
// One brightness channel: double-buffered duty (pending -> active on wrap)
// and a registered compare output.
// Ports:
//   clk, reset   clock, async active-high reset
//   wr_en        load wr_data into pending duty
//   wr_data      new duty in clk cycles high per period
//   wrap         counter wraps on this edge; active takes pending
//   next_count   counter value for the next cycle
//   enable       0 = hold the output
//   bright       registered PWM output
module multi_channel_pwm_clock_pwm_channel
    import multi_channel_pwm_clock_pkg::*;
#(
    parameter int unsigned CNT_W        = DEF_CNT_W,
    parameter int unsigned DEFAULT_DUTY = DEF_DUTY
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_data,
    input  logic             wrap,
    input  logic [CNT_W-1:0] next_count,
    input  logic             enable,
    output logic             bright
);

    localparam logic [CNT_W-1:0] RST_DUTY = CNT_W'(DEFAULT_DUTY);

    logic [CNT_W-1:0] pending_q, pending_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic             bright_q, bright_d;

    // Compare against the next count and the duty that will be active then,
    // so the registered output lines up with the counter with no lag.
    always_comb begin
        pending_d = pending_q;
        active_d  = active_q;
        bright_d  = bright_q;
        if (wr_en) begin
            pending_d = wr_data;
        end
        if (wrap) begin
            active_d = pending_q;
        end
        if (enable) begin
            bright_d = (next_count < active_d);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= RST_DUTY;
            active_q  <= RST_DUTY;
            bright_q  <= 1'b0;
        end else begin
            pending_q <= pending_d;
            active_q  <= active_d;
            bright_q  <= bright_d;
        end
    end

    assign bright = bright_q;

endmodule

// File: rtl/multi_channel_pwm_clock.sv
// Programmable-period tick / user clock generator with NUM_CH PWM channels.
// Ports:
//   clk, reset   clock, async active-high reset
//   enable       1 = count, 0 = freeze counter and outputs
//   duty_wr      write strobe for duty_data into channel duty_sel
//   duty_sel     channel index (out-of-range writes are dropped)
//   duty_data    duty in clk cycles high per period
//   tick         one-cycle pulse in the first cycle of each period
//   usr_clk      toggles once per period
//   bright       per-channel PWM outputs
module multi_channel_pwm_clock
    import multi_channel_pwm_clock_pkg::*;
#(
    parameter int unsigned PERIOD       = DEF_PERIOD,
    parameter int unsigned CNT_W        = DEF_CNT_W,
    parameter int unsigned NUM_CH       = DEF_NUM_CH,
    parameter int unsigned SEL_W        = sel_width(NUM_CH),
    parameter int unsigned DEFAULT_DUTY = DEF_DUTY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              duty_wr,
    input  logic [SEL_W-1:0]  duty_sel,
    input  logic [CNT_W-1:0]  duty_data,
    output logic              tick,
    output logic              usr_clk,
    output logic [NUM_CH-1:0] bright
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic             usr_clk_q, usr_clk_d;
    logic             wrap_c;

    // A wrap is only ever taken on an enabled edge.
    assign wrap_c = enable && (count_q == LAST);

    // Counter, tick and user clock next-state.
    always_comb begin
        count_d   = count_q;
        tick_d    = 1'b0;
        usr_clk_d = usr_clk_q;
        if (wrap_c) begin
            count_d   = '0;
            tick_d    = 1'b1;
            usr_clk_d = ~usr_clk_q;
        end else if (enable) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            tick_q    <= 1'b0;
            usr_clk_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            tick_q    <= tick_d;
            usr_clk_q <= usr_clk_d;
        end
    end

    assign tick    = tick_q;
    assign usr_clk = usr_clk_q;

    // Per-channel duty buffers; duty_sel decode selects at most one channel.
    for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
        logic wr_en_c;
        assign wr_en_c = duty_wr && (duty_sel == SEL_W'(i));

        multi_channel_pwm_clock_pwm_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_DUTY (DEFAULT_DUTY)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .wr_en      (wr_en_c),
            .wr_data    (duty_data),
            .wrap       (wrap_c),
            .next_count (count_d),
            .enable     (enable),
            .bright     (bright[i])
        );
    end

endmodule

// File: tb/tb_multi_channel_pwm_clock.sv
// Directed bench for multi_channel_pwm_clock with PERIOD=10, two channels.
module tb_multi_channel_pwm_clock;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       duty_wr;
    logic [0:0] duty_sel;
    logic [3:0] duty_data;
    logic       tick;
    logic       usr_clk;
    logic [1:0] bright;

    int   total;
    int   bad;
    int   cnt_exp;
    logic uclk_exp;

    multi_channel_pwm_clock #(
        .PERIOD       (10),
        .CNT_W        (4),
        .NUM_CH       (2),
        .SEL_W        (1),
        .DEFAULT_DUTY (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .duty_wr   (duty_wr),
        .duty_sel  (duty_sel),
        .duty_data (duty_data),
        .tick      (tick),
        .usr_clk   (usr_clk),
        .bright    (bright)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge with an optional duty write; tracks the expected
    // counter and user clock, then samples 1 time unit after the edge.
    task automatic cycle_w(input logic wr, input logic sel, input logic [3:0] data);
        duty_wr   = wr;
        duty_sel  = sel;
        duty_data = data;
        @(posedge clk);
        if (enable) begin
            if (cnt_exp == 9) begin
                cnt_exp  = 0;
                uclk_exp = ~uclk_exp;
            end else begin
                cnt_exp = cnt_exp + 1;
            end
        end
        #1;
        duty_wr = 1'b0;
    endtask

    task automatic cycle();
        cycle_w(1'b0, 1'b0, 4'd0);
    endtask

    task automatic run_to(input int c);
        int n;
        n = 0;
        while (cnt_exp != c && n < 20) begin
            cycle();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; duty_wr = 1'b0; duty_sel = 1'b0; duty_data = 4'd0;
        cnt_exp = 0; uclk_exp = 1'b0;
        #3;
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", tick); end
        total++; if (usr_clk !== 1'b0) begin bad++; $display("FAIL reset_usr_clk: got %b want 0", usr_clk); end
        total++; if (bright !== 2'b00) begin bad++; $display("FAIL reset_bright: got %b want 00", bright); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Tick every 10 edges, usr_clk toggles on each tick, bright stays low.
    task automatic test_tick();
        enable = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            cycle();
            total++;
            if (tick !== ((k % 10) == 0)) begin
                bad++; $display("FAIL tick k=%0d: got %b want %b", k, tick, (k % 10) == 0);
            end
            total++;
            if (usr_clk !== (((k / 10) % 2) == 1)) begin
                bad++; $display("FAIL usr_clk k=%0d: got %b want %b", k, usr_clk, ((k / 10) % 2) == 1);
            end
            total++;
            if (bright !== 2'b00) begin
                bad++; $display("FAIL tick_bright k=%0d: got %b want 00", k, bright);
            end
        end
    endtask

    // ch0=3, ch1=7 written mid-period take effect from the next period.
    task automatic test_duty();
        cycle_w(1'b1, 1'b0, 4'd3);
        cycle_w(1'b1, 1'b1, 4'd7);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (bright !== 2'b00) begin
                bad++; $display("FAIL duty_pending c=%0d: got %b want 00", cnt_exp, bright);
            end
            cycle();
        end
        for (int i = 0; i < 20; i++) begin
            int c;
            c = i % 10;
            total++;
            if (bright[0] !== (c < 3)) begin
                bad++; $display("FAIL duty_ch0 c=%0d: got %b want %b", c, bright[0], c < 3);
            end
            total++;
            if (bright[1] !== (c < 7)) begin
                bad++; $display("FAIL duty_ch1 c=%0d: got %b want %b", c, bright[1], c < 7);
            end
            cycle();
        end
    endtask

    // Rewrite ch0 3->5 at counter 4: current period keeps 3, next gets 5.
    task automatic test_mid_rewrite();
        for (int i = 0; i < 20; i++) begin
            int   c;
            logic e0;
            c  = i % 10;
            e0 = (i < 10) ? (c < 3) : (c < 5);
            total++;
            if (bright[0] !== e0) begin
                bad++; $display("FAIL rewrite_ch0 i=%0d: got %b want %b", i, bright[0], e0);
            end
            total++;
            if (bright[1] !== (c < 7)) begin
                bad++; $display("FAIL rewrite_ch1 i=%0d: got %b want %b", i, bright[1], c < 7);
            end
            if (i == 4) cycle_w(1'b1, 1'b0, 4'd5);
            else        cycle();
        end
    endtask

    // Duty 0 is constantly low; duty 10 and 15 are constantly high across wraps.
    task automatic test_edges();
        for (int i = 0; i < 40; i++) begin
            int   c;
            logic e0;
            logic e1;
            c  = i % 10;
            e0 = (i < 10) ? (c < 5) : 1'b0;
            e1 = (i < 10) ? (c < 7) : 1'b1;
            total++;
            if (bright[0] !== e0) begin
                bad++; $display("FAIL edge_ch0 i=%0d: got %b want %b", i, bright[0], e0);
            end
            total++;
            if (bright[1] !== e1) begin
                bad++; $display("FAIL edge_ch1 i=%0d: got %b want %b", i, bright[1], e1);
            end
            if (i == 2)       cycle_w(1'b1, 1'b0, 4'd0);
            else if (i == 3)  cycle_w(1'b1, 1'b1, 4'd10);
            else if (i == 15) cycle_w(1'b1, 1'b1, 4'd15);
            else              cycle();
        end
    endtask

    // ch0=6 mid-period, then ch0=4 on the wrap edge: 6 next period, 4 after.
    task automatic test_wrap_write();
        for (int i = 0; i < 30; i++) begin
            int   c;
            logic e0;
            c  = i % 10;
            e0 = (i < 10) ? 1'b0 : ((i < 20) ? (c < 6) : (c < 4));
            total++;
            if (bright[0] !== e0) begin
                bad++; $display("FAIL wrapwr_ch0 i=%0d: got %b want %b", i, bright[0], e0);
            end
            total++;
            if (bright[1] !== 1'b1) begin
                bad++; $display("FAIL wrapwr_ch1 i=%0d: got %b want 1", i, bright[1]);
            end
            if (i == 3)      cycle_w(1'b1, 1'b0, 4'd6);
            else if (i == 9) cycle_w(1'b1, 1'b0, 4'd4);
            else             cycle();
        end
    endtask

    // Freeze for 4 edges at counter 6; the next tick then needs 4 enabled edges.
    task automatic test_enable();
        int n;
        run_to(6);
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            total++;
            if (tick !== 1'b0) begin bad++; $display("FAIL freeze_tick i=%0d: got %b want 0", i, tick); end
            total++;
            if (usr_clk !== uclk_exp) begin
                bad++; $display("FAIL freeze_usr_clk i=%0d: got %b want %b", i, usr_clk, uclk_exp);
            end
            total++;
            if (bright !== 2'b10) begin bad++; $display("FAIL freeze_bright i=%0d: got %b want 10", i, bright); end
        end
        enable = 1'b1;
        n = 0;
        while (tick !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
        total++;
        if (n != 4) begin bad++; $display("FAIL reenable_tick_delay: got %0d edges want 4", n); end
        total++;
        if (usr_clk !== uclk_exp) begin
            bad++; $display("FAIL reenable_usr_clk: got %b want %b", usr_clk, uclk_exp);
        end
    endtask

    // Async reset between edges clears outputs at once and restores default duties.
    task automatic test_async_reset();
        run_to(3);
        total++;
        if (bright !== 2'b11) begin bad++; $display("FAIL pre_reset_bright: got %b want 11", bright); end
        #2;
        reset = 1'b1;
        #1;
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL async_tick: got %b want 0", tick); end
        total++; if (usr_clk !== 1'b0) begin bad++; $display("FAIL async_usr_clk: got %b want 0", usr_clk); end
        total++; if (bright !== 2'b00) begin bad++; $display("FAIL async_bright: got %b want 00", bright); end
        @(posedge clk);
        #3;
        reset    = 1'b0;
        cnt_exp  = 0;
        uclk_exp = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            total++;
            if (tick !== (k == 10 || k == 20)) begin
                bad++; $display("FAIL post_reset_tick k=%0d: got %b want %b", k, tick, (k == 10 || k == 20));
            end
            total++;
            if (usr_clk !== (k >= 10 && k < 20)) begin
                bad++; $display("FAIL post_reset_usr_clk k=%0d: got %b want %b", k, usr_clk, (k >= 10 && k < 20));
            end
            total++;
            if (bright !== 2'b00) begin
                bad++; $display("FAIL post_reset_bright k=%0d: got %b want 00", k, bright);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_tick();
        test_duty();
        test_mid_rewrite();
        test_edges();
        test_wrap_write();
        test_enable();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
